// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply controller: FSM state encoding
// and the address-concatenation helper used to build {row,col} addresses.
package matmul_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_CLR    = 3'd3,
    S_MAC    = 3'd4,
    S_DRAIN  = 3'd5,
    S_WRITE  = 3'd6,
    S_DONE   = 3'd7
  } state_e;

  // Places hi above lo (lo occupying lo_w bits); caller truncates to its address width.
  function automatic logic [63:0] addr_cat(input logic [31:0] hi,
                                           input logic [31:0] lo,
                                           input int unsigned lo_w);
    return ({32'd0, hi} << lo_w) | {32'd0, lo};
  endfunction

endpackage

// File: rtl/matmul_controller_if.sv
// Control bundle between the matmul controller (master) and the datapath /
// stream source (slave): start/in_valid inputs plus all memory and MAC controls.
interface matmul_controller_if #(
  parameter int M = 8,
  parameter int N = 8
);
  logic           start;
  logic           in_valid;
  logic           m1EN, m1rEN, m1wEN;
  logic           m2EN, m2rEN, m2wEN;
  logic           m3EN, m3rEN, m3wEN;
  logic           mult_ld;
  logic           mult_rst;
  logic [M+N-1:0] addr1;
  logic [M+N-1:0] addr2;
  logic [M+N-1:0] addr3;
  logic           busy;
  logic           done;

  modport master (
    input  start, in_valid,
    output m1EN, m1rEN, m1wEN, m2EN, m2rEN, m2wEN, m3EN, m3rEN, m3wEN,
           mult_ld, mult_rst, addr1, addr2, addr3, busy, done
  );

  modport slave (
    output start, in_valid,
    input  m1EN, m1rEN, m1wEN, m2EN, m2rEN, m2wEN, m3EN, m3rEN, m3wEN,
           mult_ld, mult_rst, addr1, addr2, addr3, busy, done
  );
endinterface

// File: rtl/mm_idx_counter.sv
// Width-parameterised index counter with synchronous clear (priority over
// increment) and a carry-out that flags an increment from all-ones.
module mm_idx_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise increment with natural wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + W'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign wrap = inc && !clr && (&cnt_q);

endmodule

// File: rtl/matmul_controller.sv
// Matrix-multiply controller: loads A then B from the serial stream, then walks
// (i,j,k) driving the MAC and result memory, one C element per 2^N+3 cycles.
// Optional build macro MATMUL_PERF_CNT_EN adds a saturating busy-cycle counter
// output cycle_cnt.
//
// state    | meaning
// IDLE     | waiting for start, all outputs low
// LOAD_A   | writing stream words into A memory at linear address
// LOAD_B   | writing stream words into B memory at linear address
// CLR      | clear MAC register, reset k
// MAC      | read A{i,k}, B{k,j}; accumulate previous product
// DRAIN    | accumulate the last product
// WRITE    | store accumulator at C{i,j}, advance j (and i on wrap)
// DONE     | one-cycle completion pulse
module matmul_controller
  import matmul_pkg::*;
#(
  parameter int M = 8,
  parameter int N = 8
) (
  input logic                 clk,
  input logic                 rst,
`ifdef MATMUL_PERF_CNT_EN
  output logic [31:0]         cycle_cnt,
`endif
  matmul_controller_if.master bus
);

  localparam int ADDR_W = M + N;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] lin_cnt;
  logic [M-1:0]      i_cnt, j_cnt;
  logic [N-1:0]      k_cnt;
  logic              lin_wrap, i_wrap, j_wrap, k_wrap;
  logic              lin_inc, lin_clr, k_inc, k_clr, j_inc, ij_clr;
  logic              start_acc;

  logic              m1_en, m1_ren, m1_wen, m2_en, m2_ren, m2_wen, m3_en, m3_wen;
  logic              mult_ld, mult_rst, done;
  logic [ADDR_W-1:0] addr1, addr2, addr3;

  mm_idx_counter #(.W(ADDR_W)) u_lin_cnt (
    .clk(clk), .rst(rst), .clr(lin_clr), .inc(lin_inc), .cnt(lin_cnt), .wrap(lin_wrap)
  );

  mm_idx_counter #(.W(M)) u_i_cnt (
    .clk(clk), .rst(rst), .clr(ij_clr), .inc(j_wrap), .cnt(i_cnt), .wrap(i_wrap)
  );

  mm_idx_counter #(.W(M)) u_j_cnt (
    .clk(clk), .rst(rst), .clr(ij_clr), .inc(j_inc), .cnt(j_cnt), .wrap(j_wrap)
  );

  mm_idx_counter #(.W(N)) u_k_cnt (
    .clk(clk), .rst(rst), .clr(k_clr), .inc(k_inc), .cnt(k_cnt), .wrap(k_wrap)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and datapath control; addresses held at zero outside their phase.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    lin_inc   = 1'b0;
    lin_clr   = 1'b0;
    k_inc     = 1'b0;
    k_clr     = 1'b0;
    j_inc     = 1'b0;
    ij_clr    = 1'b0;
    m1_en     = 1'b0;
    m1_ren    = 1'b0;
    m1_wen    = 1'b0;
    m2_en     = 1'b0;
    m2_ren    = 1'b0;
    m2_wen    = 1'b0;
    m3_en     = 1'b0;
    m3_wen    = 1'b0;
    mult_ld   = 1'b0;
    mult_rst  = 1'b0;
    done      = 1'b0;
    addr1     = '0;
    addr2     = '0;
    addr3     = '0;

    case (state_q)
      S_IDLE: begin
        lin_clr = 1'b1;
        ij_clr  = 1'b1;
        if (bus.start) begin
          start_acc = 1'b1;
          state_d   = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        if (bus.in_valid) begin
          m1_en   = 1'b1;
          m1_wen  = 1'b1;
          addr1   = lin_cnt;
          lin_inc = 1'b1;
          if (lin_wrap) state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (bus.in_valid) begin
          m2_en   = 1'b1;
          m2_wen  = 1'b1;
          addr2   = lin_cnt;
          lin_inc = 1'b1;
          if (lin_wrap) state_d = S_CLR;
        end
      end
      S_CLR: begin
        mult_rst = 1'b1;
        k_clr    = 1'b1;
        state_d  = S_MAC;
      end
      S_MAC: begin
        m1_en  = 1'b1;
        m1_ren = 1'b1;
        m2_en  = 1'b1;
        m2_ren = 1'b1;
        addr1  = ADDR_W'(addr_cat(32'(i_cnt), 32'(k_cnt), N));
        addr2  = ADDR_W'(addr_cat(32'(k_cnt), 32'(j_cnt), M));
        // Read data lags by one cycle, so the first MAC cycle has nothing to add.
        mult_ld = (k_cnt != '0);
        k_inc   = 1'b1;
        if (k_wrap) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        mult_ld = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        m3_en  = 1'b1;
        m3_wen = 1'b1;
        addr3  = ADDR_W'(addr_cat(32'(i_cnt), 32'(j_cnt), M));
        j_inc  = 1'b1;
        // i wraps exactly when the last element (i=j=max) is written.
        state_d = i_wrap ? S_DONE : S_CLR;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.m1EN     = m1_en;
  assign bus.m1rEN    = m1_ren;
  assign bus.m1wEN    = m1_wen;
  assign bus.m2EN     = m2_en;
  assign bus.m2rEN    = m2_ren;
  assign bus.m2wEN    = m2_wen;
  assign bus.m3EN     = m3_en;
  assign bus.m3rEN    = 1'b0;
  assign bus.m3wEN    = m3_wen;
  assign bus.mult_ld  = mult_ld;
  assign bus.mult_rst = mult_rst;
  assign bus.addr1    = addr1;
  assign bus.addr2    = addr2;
  assign bus.addr3    = addr3;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done;

`ifdef MATMUL_PERF_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  // Busy-cycle count: cleared on start accept, saturating, held while idle.
  always_comb begin
    cyc_d = cyc_q;
    if (start_acc)
      cyc_d = '0;
    else if ((state_q != S_IDLE) && (cyc_q != 32'hFFFF_FFFF))
      cyc_d = cyc_q + 32'd1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cyc_q <= '0;
    else      cyc_q <= cyc_d;
  end

  assign cycle_cnt = cyc_q;
`endif

endmodule

// File: tb/tb_matmul_controller.sv
// Self-checking bench for matmul_controller (M=N=1) with a behavioural
// datapath model and scoreboards for A/B load addresses and C results.
module tb_matmul_controller;

  localparam int M  = 1;
  localparam int N  = 1;
  localparam int AW = M + N;
  localparam int D  = 1 << AW;
  localparam int SZ = 1 << M;
  localparam int KZ = 1 << N;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  matmul_controller_if #(.M(M), .N(N)) bus ();

`ifdef MATMUL_PERF_CNT_EN
  logic [31:0] cycle_cnt;
`endif

  matmul_controller #(.M(M), .N(N)) dut (
    .clk(clk),
    .rst(rst),
`ifdef MATMUL_PERF_CNT_EN
    .cycle_cnt(cycle_cnt),
`endif
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural datapath.
  logic [15:0] data_in;
  logic [15:0] a_mem [D];
  logic [15:0] b_mem [D];
  logic [31:0] c_mem [D];
  logic [15:0] a_rd, b_rd;
  logic [31:0] acc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_rd <= '0;
      b_rd <= '0;
      acc  <= '0;
    end else begin
      if (bus.m1EN && bus.m1wEN) a_mem[bus.addr1] <= data_in;
      if (bus.m2EN && bus.m2wEN) b_mem[bus.addr2] <= data_in;
      if (bus.m1EN && bus.m1rEN) a_rd <= a_mem[bus.addr1];
      if (bus.m2EN && bus.m2rEN) b_rd <= b_mem[bus.addr2];
      if (bus.mult_rst)     acc <= '0;
      else if (bus.mult_ld) acc <= acc + a_rd * b_rd;
      if (bus.m3EN && bus.m3wEN) c_mem[bus.addr3] <= acc;
    end
  end

  // Scoreboards.
  int a_q[$];
  int b_q[$];
  int c_addr_q[$];
  int c_val_q[$];
  int a_wr_cnt  = 0;
  int done_seen = 0;
  int mat_a [D];
  int mat_b [D];

  logic [63:0] out_vec;
  assign out_vec = 64'({bus.m1EN, bus.m1rEN, bus.m1wEN, bus.m2EN, bus.m2rEN, bus.m2wEN,
                        bus.m3EN, bus.m3rEN, bus.m3wEN, bus.mult_ld, bus.mult_rst,
                        bus.addr1, bus.addr2, bus.addr3, bus.busy, bus.done});

  always @(negedge clk) begin
    if (rst) begin
      if (bus.m1wEN) begin
        a_wr_cnt++;
        if (bus.in_valid !== 1'b1) check("a_wr_no_valid", 64'(bus.in_valid), 64'd1);
        if (a_q.size() == 0) check("a_wr_extra", 64'd1, 64'd0);
        else check("a_wr_addr", 64'(bus.addr1), 64'(a_q.pop_front()));
      end
      if (bus.m2wEN) begin
        if (bus.in_valid !== 1'b1) check("b_wr_no_valid", 64'(bus.in_valid), 64'd1);
        if (b_q.size() == 0) check("b_wr_extra", 64'd1, 64'd0);
        else check("b_wr_addr", 64'(bus.addr2), 64'(b_q.pop_front()));
      end
      if (bus.m3wEN) begin
        if (c_addr_q.size() == 0) check("c_wr_extra", 64'd1, 64'd0);
        else begin
          check("c_wr_addr", 64'(bus.addr3), 64'(c_addr_q.pop_front()));
          check("c_wr_val", 64'(acc), 64'(c_val_q.pop_front()));
        end
      end
      if (bus.m3rEN) check("m3rEN_low", 64'(bus.m3rEN), 64'd0);
      if (bus.done) done_seen++;
    end
  end

  task automatic push_expected();
    int s;
    for (int i = 0; i < SZ; i++)
      for (int j = 0; j < SZ; j++) begin
        s = 0;
        for (int k = 0; k < KZ; k++) s += mat_a[i*KZ+k] * mat_b[k*SZ+j];
        c_addr_q.push_back(i*SZ + j);
        c_val_q.push_back(s);
      end
  endtask

  task automatic load_mats(input bit gaps, output int load_cyc);
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    load_cyc = 0;
    for (int m = 0; m < 2; m++)
      for (int w = 0; w < D; w++) begin
        if (gaps && m == 0 && w != 0) begin
          bus.in_valid = 1'b0;
          data_in = 16'hDEAD;
          @(posedge clk); #1;
          load_cyc++;
        end
        bus.in_valid = 1'b1;
        data_in = (m == 0) ? 16'(mat_a[w]) : 16'(mat_b[w]);
        if (m == 0) a_q.push_back(w);
        else        b_q.push_back(w);
        @(posedge clk); #1;
        load_cyc++;
      end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit noise, output int lat);
    lat = 0;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      if (noise && c <= 10) begin
        bus.start    = c[0];
        bus.in_valid = ~c[0];
      end else begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic run(input string tag, input bit gaps, input bit noise);
    int lc, lat, d0;
    d0 = done_seen;
    push_expected();
    load_mats(gaps, lc);
    wait_done(noise, lat);
    check({tag, "_done_lat"}, 64'(lat), 64'd20);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
    check({tag, "_done_cnt"}, 64'(done_seen - d0), 64'd1);
    check({tag, "_c_left"}, 64'(c_addr_q.size()), 64'd0);
    check({tag, "_ab_left"}, 64'(a_q.size() + b_q.size()), 64'd0);
`ifdef MATMUL_PERF_CNT_EN
    check({tag, "_cycle_cnt"}, 64'(cycle_cnt), 64'(lc + 21));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lc;
    bit hit;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    data_in      = '0;

    #1 check("reset_outputs", out_vec, 64'd0);
`ifdef MATMUL_PERF_CNT_EN
    check("reset_cycle_cnt", 64'(cycle_cnt), 64'd0);
`endif
    #20 rst = 1'b1;

    // Nominal load and compute.
    mat_a = '{1, 2, 3, 4};
    mat_b = '{5, 6, 7, 8};
    run("basic", 1'b0, 1'b0);
    check("c_mem0", 64'(c_mem[0]), 64'd19);
    check("c_mem1", 64'(c_mem[1]), 64'd22);
    check("c_mem2", 64'(c_mem[2]), 64'd43);
    check("c_mem3", 64'(c_mem[3]), 64'd50);

    // Stalls during LOAD_A.
    mat_a = '{2, 0, 7, 3};
    mat_b = '{9, 1, 4, 6};
    a_wr_cnt = 0;
    run("gaps", 1'b1, 1'b0);
    check("gaps_a_writes", 64'(a_wr_cnt), 64'd4);

    // start / in_valid toggled while computing.
    mat_a = '{11, 5, 1, 300};
    mat_b = '{3, 250, 17, 2};
    run("noise", 1'b0, 1'b1);

    // Reset in the middle of MAC.
    mat_a = '{1, 1, 1, 1};
    mat_b = '{1, 1, 1, 1};
    load_mats(1'b0, lc);
    hit = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.m1rEN) begin
        hit = 1'b1;
        break;
      end
    end
    check("mac_reached", 64'(hit), 64'd1);
    #2 rst = 1'b0;
    #1 check("midrst_outputs", out_vec, 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("midrst_hold", out_vec, 64'd0);
    c_addr_q.delete();
    c_val_q.delete();
    a_q.delete();
    b_q.delete();
    #1 rst = 1'b1;

    // Recovery after reset.
    mat_a = '{4, 3, 2, 1};
    mat_b = '{1, 2, 3, 4};
    run("recover", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
